// File: rtl/vproc_cfg_unit.sv
// ---------------------------------------------------------------------------
// vproc_cfg_unit
//
// Executes vsetvl/vsetvli/vsetivli for the vector core. Holds the architectural
// vsew/lmul/vl/vill/agnostic state and returns the new vl to the scalar
// register file. A change of vsew or lmul waits until in-flight vector
// instructions (busy_i) have drained.
//
// Build option:
//   VPROC_CFG_FRAC_LMUL_EN  defined   : fractional LMUL (F2/F4/F8) is legal
//                           undefined : any fractional LMUL sets vill
//
// Ports:
//   clk_i, async_rst_ni         clock, asynchronous active-low reset
//   op_valid_i / op_ready_o     configuration op handshake
//   op_mode_i                   packed op_mode_cfg (vsew, lmul, agnostic,
//                               vlmax, keep_vl)
//   avl_i, rd_i                 application vector length, scalar destination
//   busy_i                      vector instructions still in flight
//   res_valid_o / res_ready_i   new-vl writeback handshake
//   res_addr_o, res_data_o      writeback destination and zero-extended vl
//   vsew_o, lmul_o, vl_o,
//   vill_o, agnostic_o          current configuration
// ---------------------------------------------------------------------------
package vproc_cfg_pkg;
    localparam logic [1:0] VSEW_8       = 2'd0;
    localparam logic [1:0] VSEW_16      = 2'd1;
    localparam logic [1:0] VSEW_32      = 2'd2;
    localparam logic [1:0] VSEW_INVALID = 2'd3;

    // lmul is encoded as its signed log2 so that $signed(lmul) == lmul_s
    localparam logic [2:0] LMUL_1       = 3'b000;
    localparam logic [2:0] LMUL_2       = 3'b001;
    localparam logic [2:0] LMUL_4       = 3'b010;
    localparam logic [2:0] LMUL_8       = 3'b011;
    localparam logic [2:0] LMUL_INVALID = 3'b100;
    localparam logic [2:0] LMUL_F8      = 3'b101;
    localparam logic [2:0] LMUL_F4      = 3'b110;
    localparam logic [2:0] LMUL_F2      = 3'b111;

    typedef struct packed {
        logic [1:0] vsew;
        logic [2:0] lmul;
        logic [1:0] agnostic;
        logic       vlmax;
        logic       keep_vl;
    } op_mode_cfg;
endpackage

module vproc_cfg_unit
    import vproc_cfg_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
    input  logic                           clk_i,
    input  logic                           async_rst_ni,
    input  logic                           op_valid_i,
    output logic                           op_ready_o,
    input  logic [$bits(op_mode_cfg)-1:0]  op_mode_i,
    input  logic [31:0]                    avl_i,
    input  logic [4:0]                     rd_i,
    input  logic                           busy_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [4:0]                     res_addr_o,
    output logic [31:0]                    res_data_o,
    output logic [1:0]                     vsew_o,
    output logic [2:0]                     lmul_o,
    output logic [VL_W-1:0]                vl_o,
    output logic                           vill_o,
    output logic [1:0]                     agnostic_o
);

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, RESP} state_e;

    localparam logic signed [5:0] LOG2_VREG = 6'($clog2(VREG_W));

    state_e           state_q, state_d;
    op_mode_cfg       mode_q;
    logic [31:0]      avl_q;
    logic [4:0]       rd_q;
    logic [1:0]       vsew_q, agnostic_q;
    logic [2:0]       lmul_q;
    logic [VL_W-1:0]  vl_q;
    logic             vill_q;
    logic [4:0]       res_addr_q;
    logic [31:0]      res_data_q;

    logic             accept, commit;
    logic             illegal, same_cfg;
    logic signed [5:0] sew_new_s, lmul_new_s, sew_cur_s, lmul_cur_s;
    logic signed [5:0] lmul_vl_s, log2_vlmax;
    logic [VL_W-1:0]  vlmax_vl, new_vl;

    // ---------------------------------------------------------------------
    // New configuration, derived from the captured op and current state
    // ---------------------------------------------------------------------
    always_comb begin
        sew_new_s  = {4'b0000, mode_q.vsew};
        lmul_new_s = {{3{mode_q.lmul[2]}}, mode_q.lmul};
        sew_cur_s  = {4'b0000, vsew_q};
        lmul_cur_s = {{3{lmul_q[2]}}, lmul_q};

        illegal = (mode_q.vsew == VSEW_INVALID)
               || (mode_q.lmul == LMUL_INVALID)
               || (sew_new_s > 6'sd2 + lmul_new_s)
               || (mode_q.keep_vl &&
                   ((sew_new_s - lmul_new_s) != (sew_cur_s - lmul_cur_s)));
`ifdef VPROC_CFG_FRAC_LMUL_EN
        lmul_vl_s = lmul_new_s;
`else
        // Fractional encodings are all illegal here, so only 1..8 are sized.
        illegal   = illegal || mode_q.lmul[2];
        lmul_vl_s = {4'b0000, mode_q.lmul[1:0]};
`endif
        log2_vlmax = LOG2_VREG + lmul_vl_s - 6'sd3 - sew_new_s;
        // Only meaningful when legal; legality keeps the exponent >= 0.
        vlmax_vl   = {{(VL_W-1){1'b0}}, 1'b1} << log2_vlmax[4:0];

        same_cfg = (mode_q.vsew == vsew_q) && (mode_q.lmul == lmul_q);

        if (illegal) begin
            new_vl = '0;
        end else if (mode_q.keep_vl) begin
            new_vl = vl_q;
        end else if (mode_q.vlmax) begin
            new_vl = vlmax_vl;
        end else if (avl_q < 32'(vlmax_vl)) begin
            new_vl = avl_q[VL_W-1:0];
        end else begin
            new_vl = vlmax_vl;
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Illegal or unchanged vsew/lmul never needs the pipeline drained.
                if (illegal || same_cfg || !busy_i) begin
                    commit = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy_i) begin
                    commit = 1'b1;
                end
            end
            RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            state_d = (rd_q != 5'd0) ? RESP : IDLE;
        end
    end

    // ---------------------------------------------------------------------
    // Captured op, architectural config and writeback registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            mode_q     <= '0;
            avl_q      <= '0;
            rd_q       <= '0;
            vsew_q     <= VSEW_8;
            lmul_q     <= LMUL_1;
            vl_q       <= '0;
            vill_q     <= 1'b1;
            agnostic_q <= '0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            if (accept) begin
                mode_q <= op_mode_cfg'(op_mode_i);
                avl_q  <= avl_i;
                rd_q   <= rd_i;
            end
            if (commit) begin
                vill_q     <= illegal;
                vl_q       <= new_vl;
                vsew_q     <= illegal ? VSEW_8 : mode_q.vsew;
                lmul_q     <= illegal ? LMUL_1 : mode_q.lmul;
                agnostic_q <= illegal ? 2'b00  : mode_q.agnostic;
                if (rd_q != 5'd0) begin
                    res_addr_q <= rd_q;
                    res_data_q <= 32'(new_vl);
                end
            end
        end
    end

    assign vsew_o     = vsew_q;
    assign lmul_o     = lmul_q;
    assign vl_o       = vl_q;
    assign vill_o     = vill_q;
    assign agnostic_o = agnostic_q;
    assign res_addr_o = res_addr_q;
    assign res_data_o = res_data_q;

endmodule

// File: doc/vproc_cfg_unit.md
# vproc_cfg_unit

Executes vector configuration instructions (vsetvl/vsetvli/vsetivli) for the vector core. Sits directly downstream of the decoder, consuming the decoded `op_mode_cfg` field together with the AVL scalar operand. It holds the architectural vsew/lmul/vl/vill state used by all execution units and returns the new vl to the scalar register file. When vsew or lmul changes, it stalls the update until in-flight vector instructions drain.

## Interface
- `VREG_W`, 128: vector register width in bits (power of two, ≥64)
- `VL_W`, `$clog2(VREG_W)+1`: vl width in bits (max vl = `VREG_W`, reached at e8/m8)

- `clk_i` in 1: clock
- `async_rst_ni` in 1: asynchronous active-low reset
- `op_valid_i` in 1: configuration op offered
- `op_ready_o` out 1: op accepted when both high at rising edge
- `op_mode_i` in `$bits(op_mode_cfg)`: vsew, lmul, agnostic, vlmax, keep_vl
- `avl_i` in 32: application vector length (rs1 value or immediate)
- `rd_i` in 5: scalar destination
- `busy_i` in 1: vector instructions using the current config are still in flight
- `res_valid_o` out 1: new vl is ready for scalar writeback
- `res_ready_i` in 1: writeback accepted
- `res_addr_o` out 5: scalar destination
- `res_data_o` out 32: new vl, zero-extended
- `vsew_o` out 2, `lmul_o` out 3, `vl_o` out `VL_W`, `vill_o` out 1, `agnostic_o` out 2: current configuration

## Operation
- FSM states:
  - IDLE: `op_ready_o`=1. On accept, capture inputs and go to CALC.
  - CALC: compute the new config.
    - If illegal, or if vsew/lmul both equal current, or if `busy_i`=0: commit.
    - Otherwise go to DRAIN.
  - DRAIN: wait. Commit in the cycle in which `busy_i`=0.
  - Commit: register the new config. Go to RESP if `rd_i`≠0, else to IDLE.
  - RESP: `res_valid_o`=1, holding `res_addr_o` and `res_data_o` stable. On `res_ready_i`=1, go to IDLE.
- lmul sign: lmul_s = signed 3-bit lmul (F8=-3, F4=-2, F2=-1, 1=0 … 8=3). log2(VLMAX) = log2(`VREG_W`) + lmul_s − (3 + vsew).
- Illegal (vill) when any of the following holds:
  - vsew = `VSEW_INVALID`
  - lmul = `LMUL_INVALID`
  - vsew > 2 + lmul_s (SEW > ELEN·LMUL, ELEN=32)
  - keep_vl is set and the ratio vsew−lmul_s differs from the current config's ratio
- New vl:
  - keep_vl: current vl
  - else vlmax: VLMAX
  - else: min(`avl_i`, VLMAX), compared at the full 32 bits
- Illegal commit: `vill_o`=1, `vl_o`=0, `vsew_o`=`VSEW_8`, `lmul_o`=`LMUL_1`, `agnostic_o`=0, `res_data_o`=0.
- Legal commit: `vill_o`=0 and the captured fields are loaded.

## Timing
- Reset values:
  - state IDLE, `op_ready_o`=1
  - `res_valid_o`=0, `res_addr_o`=0, `res_data_o`=0
  - `vill_o`=1, `vl_o`=0, `vsew_o`=`VSEW_8`, `lmul_o`=`LMUL_1`, `agnostic_o`=0
- Latency: accept at edge T. CALC occupies cycle T+1. Config outputs change and `res_valid_o` rises at edge T+2 (no drain).
- DRAIN: commit happens at the edge ending the first cycle with `busy_i`=0. Outputs keep the old config until then.
- One op in flight; `op_ready_o`=0 in CALC, DRAIN, and RESP. A back-to-back op is accepted in the first cycle after leaving RESP.
- `res_valid_o`, once high, stays high with stable data until `res_ready_i`.
- `busy_i` is sampled only in CALC and DRAIN. Toggling it elsewhere has no effect.
- Reset asserted in any state returns to reset values asynchronously. The pending op is discarded and no result is produced.

## Configuration
- `VPROC_CFG_FRAC_LMUL_EN` defined: fractional LMUL (F2/F4/F8) is legal, subject to the vsew ≤ 2 + lmul_s rule.
- Not defined: any fractional LMUL is treated as illegal (vill), and VLMAX logic covers only lmul_s ≥ 0.

## Test plan
- `VREG_W`=128; e8/m1, `avl_i`=20, rd=5 → `res_valid_o` at T+2, `res_data_o`=16, `res_addr_o`=5, `vl_o`=16, `vill_o`=0.
- e16/m2, `avl_i`=7 → 7. Then vlmax=1, e32/m8 with `busy_i`=1 for 5 cycles → `vl_o` stays 7 through DRAIN; `res_data_o`=32 one edge after `busy_i` falls.
- From e16/m2, keep_vl with e8/m1 (same ratio) → vl unchanged. keep_vl with e32/m1 (ratio change) → `vill_o`=1, `vl_o`=0, `res_data_o`=0.
- Macro defined: e8/mf2, `avl_i`=100 → 8; e32/mf2 → vill. Macro undefined: e8/mf2 → vill.
- rd=0, e8/m4, `avl_i`=0xFFFF_FFFF → no `res_valid_o`, `vl_o`=64, `op_ready_o`=1 at T+2. `res_ready_i` held low 3 cycles in RESP → data stable, no new op accepted.
- Reset asserted during DRAIN → immediate reset values; `res_valid_o` never rises for that op.
